cavlc_level_decoder: RTL and testbench

- Self-sequencing CAVLC level decoder for one residual block.
- Decodes trailing-ones signs, level_prefix, level_suffix and the suffixLength adaptation, and stores signed levels into a parametrised coefficient buffer.
- Consumes bits from the bitstream window through a bits_used / bs_valid handshake.
- Sits between the coeff_token stage and the total_zeros/run_before stage of the CAVLC decoder; serves luma (16), AC (15) and chroma DC (4) blocks.

---
 rtl/cavlc_level_decoder.sv | 194 +++++++++++++++++++
 tb/tb_cavlc_level_decoder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cavlc_level_decoder.sv
// CAVLC level decoder: trailing-ones signs, level_prefix/level_suffix, suffixLength adaptation.
// Define CAVLC_HIGH_PREFIX_EN to accept level_prefix 16..19 with the escape offset.
module cavlc_level_decoder #(
    parameter int MAX_COEFF = 16,
    parameter int LEVEL_W   = 16,
    parameter int WIN_W     = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [4:0]                     total_coeff,
    input  logic [1:0]                     trailing_ones,
    input  logic [4:0]                     max_num_coeff,
    input  logic [WIN_W-1:0]               bs_window,
    input  logic                           bs_valid,
    output logic [4:0]                     bits_used,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [MAX_COEFF*LEVEL_W-1:0]   level_flat
);

    localparam int CW = LEVEL_W + 2;
    localparam int IW = (MAX_COEFF > 1) ? $clog2(MAX_COEFF) : 1;
`ifdef CAVLC_HIGH_PREFIX_EN
    localparam int PSCAN = 20;
    localparam int PMAX  = 19;
`else
    localparam int PSCAN = 16;
    localparam int PMAX  = 15;
`endif

    typedef enum logic [2:0] {S_IDLE, S_T1, S_PREFIX, S_SUFFIX, S_DONE} state_e;

    state_e                                  state_q, state_d;
    logic [4:0]                              idx_q, idx_d;
    logic [2:0]                              sl_q, sl_d;
    logic [4:0]                              prefix_q, prefix_d;
    logic [4:0]                              tc_q, tc_d;
    logic [1:0]                              t1_q, t1_d;
    logic                                    error_q, error_d;
    logic [MAX_COEFF-1:0][LEVEL_W-1:0]       levels_q, levels_d;

    logic [4:0]    lz;
    logic [4:0]    sfx_size;
    logic [15:0]   sfx_top, level_suffix;
    logic [3:0]    pmin;
    logic [CW-1:0] lc, lvl_mag, level_full, thr;
    logic [2:0]    sl_base, sl_new;

    // Leading-zero count over the scan range; PSCAN means no '1' was found.
    always_comb begin
        lz = 5'(PSCAN);
        for (int k = PSCAN - 1; k >= 0; k--) begin
            if (bs_window[WIN_W-1-k]) lz = 5'(k);
        end
    end

    always_comb begin
        if (prefix_q == 5'd14 && sl_q == 3'd0)
            sfx_size = 5'd4;
        else if (prefix_q >= 5'd15)
            sfx_size = prefix_q - 5'd3;
        else
            sfx_size = {2'b00, sl_q};

        sfx_top      = bs_window[WIN_W-1 -: 16];
        level_suffix = (sfx_size == 5'd0) ? 16'd0 : (sfx_top >> (5'd16 - sfx_size));
        pmin         = (prefix_q >= 5'd15) ? 4'd15 : prefix_q[3:0];

        lc = (CW'(pmin) << sl_q) + CW'(level_suffix);
        if (prefix_q >= 5'd15 && sl_q == 3'd0)
            lc = lc + CW'(15);
`ifdef CAVLC_HIGH_PREFIX_EN
        if (prefix_q >= 5'd16)
            lc = lc + (CW'(1) << (prefix_q - 5'd3)) - CW'(4096);
`endif
        // First non-T1 level can't be +/-1 when fewer than three trailing ones.
        if (idx_q == {3'b000, t1_q} && t1_q < 2'd3)
            lc = lc + CW'(2);

        lvl_mag    = lc[0] ? ((lc + CW'(1)) >> 1) : ((lc + CW'(2)) >> 1);
        level_full = lc[0] ? (-lvl_mag) : lvl_mag;

        sl_base = (sl_q == 3'd0) ? 3'd1 : sl_q;
        thr     = CW'(3) << (sl_base - 3'd1);
        sl_new  = (lvl_mag > thr && sl_base < 3'd6) ? (sl_base + 3'd1) : sl_base;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sl_d      = sl_q;
        prefix_d  = prefix_q;
        tc_d      = tc_q;
        t1_d      = t1_q;
        error_d   = error_q;
        levels_d  = levels_q;
        bits_used = 5'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    levels_d = '0;
                    tc_d     = total_coeff;
                    t1_d     = trailing_ones;
                    idx_d    = 5'd0;
                    prefix_d = 5'd0;
                    error_d  = 1'b0;
                    sl_d     = (total_coeff > 5'd10 && trailing_ones < 2'd3) ? 3'd1 : 3'd0;
                    if (total_coeff == 5'd0) begin
                        state_d = S_DONE;
                    end else if (total_coeff > max_num_coeff) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else if (trailing_ones != 2'd0) begin
                        state_d = S_T1;
                    end else begin
                        state_d = S_PREFIX;
                    end
                end
            end
            S_T1: begin
                if (bs_valid) begin
                    bits_used = {3'b000, t1_q};
                    for (int i = 0; i < 3; i++) begin
                        if (i < int'(t1_q) && i < MAX_COEFF)
                            levels_d[i] = bs_window[WIN_W-1-i] ? {LEVEL_W{1'b1}} : LEVEL_W'(1);
                    end
                    idx_d   = {3'b000, t1_q};
                    state_d = ({3'b000, t1_q} < tc_q) ? S_PREFIX : S_DONE;
                end
            end
            S_PREFIX: begin
                if (bs_valid) begin
                    if (lz > 5'(PMAX)) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        bits_used = lz + 5'd1;
                        prefix_d  = lz;
                        state_d   = S_SUFFIX;
                    end
                end
            end
            S_SUFFIX: begin
                if (bs_valid) begin
                    bits_used = sfx_size;
                    if (int'(idx_q) < MAX_COEFF)
                        levels_d[idx_q[IW-1:0]] = level_full[LEVEL_W-1:0];
                    idx_d   = idx_q + 5'd1;
                    sl_d    = sl_new;
                    state_d = ((idx_q + 5'd1) < tc_q) ? S_PREFIX : S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= 5'd0;
            sl_q     <= 3'd0;
            prefix_q <= 5'd0;
            tc_q     <= 5'd0;
            t1_q     <= 2'd0;
            error_q  <= 1'b0;
            levels_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sl_q     <= sl_d;
            prefix_q <= prefix_d;
            tc_q     <= tc_d;
            t1_q     <= t1_d;
            error_q  <= error_d;
            levels_q <= levels_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign error      = error_q;
    assign level_flat = levels_q;

    // Window bits below the prefix scan range never influence decoding.
    if (WIN_W > PSCAN) begin : g_unused
        logic unused_win;
        assign unused_win = ^bs_window[WIN_W-PSCAN-1:0];
    end

endmodule

// File: tb/tb_cavlc_level_decoder.sv
// Directed bench for cavlc_level_decoder; a small bit-stream model feeds bs_window and advances by bits_used.
module tb_cavlc_level_decoder;

    localparam int MAX_COEFF = 16;
    localparam int LEVEL_W   = 16;
    localparam int WIN_W     = 32;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         start;
    logic [4:0]                   total_coeff;
    logic [1:0]                   trailing_ones;
    logic [4:0]                   max_num_coeff;
    logic [WIN_W-1:0]             bs_window;
    logic                         bs_valid;
    logic [4:0]                   bits_used;
    logic                         busy, done, error;
    logic [MAX_COEFF*LEVEL_W-1:0] level_flat;

    logic [0:511] stream;
    int           wr_ptr;
    int           ptr;
    int           n_pass = 0;
    int           n_total = 0;
    logic [4:0]   bu_log [0:63];
    int           done_cyc;

    cavlc_level_decoder #(.MAX_COEFF(MAX_COEFF), .LEVEL_W(LEVEL_W), .WIN_W(WIN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .total_coeff(total_coeff),
        .trailing_ones(trailing_ones), .max_num_coeff(max_num_coeff),
        .bs_window(bs_window), .bs_valid(bs_valid), .bits_used(bits_used),
        .busy(busy), .done(done), .error(error), .level_flat(level_flat)
    );

    always #5 clk = ~clk;

    // Bit-stream source: consumed bits disappear from the window at the next edge.
    always @(posedge clk or posedge reset) begin
        if (reset)         ptr <= 0;
        else if (start)    ptr <= 0;
        else if (bs_valid) ptr <= ptr + int'(bits_used);
    end

    always_comb begin
        bs_window = '0;
        for (int k = 0; k < WIN_W; k++) bs_window[WIN_W-1-k] = stream[ptr+k];
    end

    function automatic logic [LEVEL_W-1:0] lvl(input int i);
        return level_flat[i*LEVEL_W +: LEVEL_W];
    endfunction

    task automatic clear_stream();
        stream = '0;
        wr_ptr = 0;
    endtask

    task automatic push(input logic [31:0] v, input int n);
        for (int k = 0; k < n; k++) stream[wr_ptr+k] = v[n-1-k];
        wr_ptr += n;
    endtask

    task automatic run_block(input logic [4:0] tc, input logic [1:0] t1, input logic [4:0] mx);
        @(negedge clk);
        total_coeff = tc; trailing_ones = t1; max_num_coeff = mx; start = 1'b1; bs_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cyc = -1;
        for (int c = 1; c < 64; c++) begin
            bu_log[c] = bits_used;
            if (done) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
        end
        n_total++;
        if (done_cyc < 0) $display("FAIL run_timeout: done not seen, got %0d want >0", done_cyc);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; bs_valid = 1'b1;
        total_coeff = '0; trailing_ones = '0; max_num_coeff = 5'd16;
        clear_stream();
        repeat (2) @(negedge clk);
        n_total++;
        if ({busy, done, error} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, error});
        else n_pass++;
        n_total++;
        if (bits_used !== 5'd0) $display("FAIL reset_bits_used: got %0d want 0", bits_used);
        else n_pass++;
        n_total++;
        if (level_flat !== '0) $display("FAIL reset_levels: got %h want 0", level_flat);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_idle: busy got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_basic();
        clear_stream();
        push(32'b11010, 5);
        run_block(5'd3, 2'd1, 5'd16);
        n_total++;
        if (done_cyc !== 6) $display("FAIL basic_latency: got %0d want 6", done_cyc);
        else n_pass++;
        n_total++;
        if ({bu_log[1], bu_log[2], bu_log[3], bu_log[4], bu_log[5]} !== {5'd1, 5'd1, 5'd0, 5'd2, 5'd1})
            $display("FAIL basic_bits_used: got %0d %0d %0d %0d %0d want 1 1 0 2 1",
                     bu_log[1], bu_log[2], bu_log[3], bu_log[4], bu_log[5]);
        else n_pass++;
        n_total++;
        if ({lvl(0), lvl(1), lvl(2)} !== {16'hFFFF, 16'd2, 16'd2})
            $display("FAIL basic_levels: got %h %h %h want ffff 0002 0002", lvl(0), lvl(1), lvl(2));
        else n_pass++;
        n_total++;
        if (level_flat[MAX_COEFF*LEVEL_W-1:3*LEVEL_W] !== '0 || error !== 1'b0 || busy !== 1'b1)
            $display("FAIL basic_tail: got upper=%h err=%b busy=%b want 0 0 1",
                     level_flat[MAX_COEFF*LEVEL_W-1:3*LEVEL_W], error, busy);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({busy, done} !== 2'b00) $display("FAIL basic_after_done: got %b want 00", {busy, done});
        else n_pass++;
    endtask

    task automatic test_zero_coeff();
        clear_stream();
        push(32'hFFFF, 16);
        run_block(5'd0, 2'd0, 5'd16);
        n_total++;
        if (done_cyc !== 1 || bu_log[1] !== 5'd0 || error !== 1'b0)
            $display("FAIL zero_coeff: got cyc=%0d bu=%0d err=%b want 1 0 0", done_cyc, bu_log[1], error);
        else n_pass++;
    endtask

    task automatic test_overflow();
        clear_stream();
        push(32'hFFFF, 16);
        run_block(5'd5, 2'd0, 5'd4);
        n_total++;
        if (done_cyc !== 1 || error !== 1'b1 || level_flat !== '0)
            $display("FAIL overflow: got cyc=%0d err=%b lv=%h want 1 1 0", done_cyc, error, level_flat);
        else n_pass++;
    endtask

    task automatic test_t1_only();
        clear_stream();
        push(32'b010, 3);
        run_block(5'd3, 2'd3, 5'd4);
        n_total++;
        if (done_cyc !== 2 || bu_log[1] !== 5'd3)
            $display("FAIL t1_only_timing: got cyc=%0d bu=%0d want 2 3", done_cyc, bu_log[1]);
        else n_pass++;
        n_total++;
        if ({lvl(0), lvl(1), lvl(2), lvl(3)} !== {16'd1, 16'hFFFF, 16'd1, 16'd0} || error !== 1'b0)
            $display("FAIL t1_only_levels: got %h %h %h %h err=%b want 0001 ffff 0001 0000 0",
                     lvl(0), lvl(1), lvl(2), lvl(3), error);
        else n_pass++;
    endtask

    task automatic test_prefix14();
        clear_stream();
        push(32'h0, 14); push(32'b1, 1); push(32'b0101, 4);
        run_block(5'd1, 2'd0, 5'd16);
        n_total++;
        if (done_cyc !== 3 || lvl(0) !== 16'hFFF5 || error !== 1'b0)
            $display("FAIL prefix14: got cyc=%0d lv0=%h err=%b want 3 fff5 0", done_cyc, lvl(0), error);
        else n_pass++;
    endtask

    task automatic test_prefix15();
        clear_stream();
        push(32'h0, 15); push(32'b1, 1); push(32'h0, 12); push(32'hFFFF, 16);
        run_block(5'd1, 2'd0, 5'd16);
        n_total++;
        if (done_cyc !== 3 || lvl(0) !== 16'd17 || error !== 1'b0)
            $display("FAIL prefix15: got cyc=%0d lv0=%h err=%b want 3 0011 0", done_cyc, lvl(0), error);
        else n_pass++;
    endtask

    task automatic test_suffix_adapt();
        logic [MAX_COEFF*LEVEL_W-1:0] exp_flat;
        clear_stream();
        push(32'b0010, 4); push(32'b000100, 6); push(32'b1101, 4);
        for (int i = 0; i < 9; i++) push(32'b1000, 4);
        exp_flat = '0;
        exp_flat[0*LEVEL_W +: LEVEL_W] = 16'd4;
        exp_flat[1*LEVEL_W +: LEVEL_W] = 16'd7;
        exp_flat[2*LEVEL_W +: LEVEL_W] = 16'hFFFD;
        for (int i = 3; i < 12; i++) exp_flat[i*LEVEL_W +: LEVEL_W] = 16'd1;
        run_block(5'd12, 2'd0, 5'd16);
        n_total++;
        if (done_cyc !== 25) $display("FAIL adapt_latency: got %0d want 25", done_cyc);
        else n_pass++;
        n_total++;
        if (level_flat !== exp_flat) $display("FAIL adapt_levels: got %h want %h", level_flat, exp_flat);
        else n_pass++;
        n_total++;
        if ({bu_log[3], bu_log[4], bu_log[6]} !== {5'd4, 5'd2, 5'd3})
            $display("FAIL adapt_suffix_sizes: got %0d %0d %0d want 4 2 3", bu_log[3], bu_log[4], bu_log[6]);
        else n_pass++;
    endtask

    task automatic test_prefix16();
        clear_stream();
        push(32'h0, 16); push(32'b1, 1); push(32'h0, 13); push(32'hFFFF, 16);
        run_block(5'd1, 2'd0, 5'd16);
`ifdef CAVLC_HIGH_PREFIX_EN
        n_total++;
        if (done_cyc !== 3 || lvl(0) !== 16'd2065 || error !== 1'b0)
            $display("FAIL prefix16: got cyc=%0d lv0=%0d err=%b want 3 2065 0", done_cyc, lvl(0), error);
        else n_pass++;
`else
        n_total++;
        if (done_cyc !== 2 || lvl(0) !== 16'd0 || error !== 1'b1)
            $display("FAIL prefix16: got cyc=%0d lv0=%0d err=%b want 2 0 1", done_cyc, lvl(0), error);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (error !== 1'b1 || busy !== 1'b0)
            $display("FAIL prefix16_sticky: got err=%b busy=%b want 1 0", error, busy);
        else n_pass++;
`endif
    endtask

    task automatic test_stall_reset();
        clear_stream();
        push(32'b1, 1); push(32'b11, 2);
        @(negedge clk);
        total_coeff = 5'd2; trailing_ones = 2'd0; max_num_coeff = 5'd16; start = 1'b1; bs_valid = 1'b1;
        @(negedge clk);
        start = 1'b0; bs_valid = 1'b0;
        #1;
        n_total++;
        if (error !== 1'b0) $display("FAIL start_clears_error: got %b want 0", error);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            n_total++;
            if ({bits_used, busy, done} !== {5'd0, 1'b1, 1'b0})
                $display("FAIL stall_hold: cycle %0d got bu=%0d busy=%b done=%b want 0 1 0", c, bits_used, busy, done);
            else n_pass++;
            if (c == 1) begin
                start = 1'b1; total_coeff = 5'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            #1;
        end
        start = 1'b0;
        n_total++;
        if (level_flat !== '0 || busy !== 1'b1) $display("FAIL stall_levels: got %h busy=%b want 0 1", level_flat, busy);
        else n_pass++;
        bs_valid = 1'b1;
        #1;
        n_total++;
        if (bits_used !== 5'd1) $display("FAIL stall_resume: got %0d want 1", bits_used);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (lvl(0) !== 16'd2 || bits_used !== 5'd1)
            $display("FAIL stall_level0: got lv0=%h bu=%0d want 0002 1", lvl(0), bits_used);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bits_used !== 5'd1) $display("FAIL stall_suffix: got %0d want 1", bits_used);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if ({busy, done, error, bits_used} !== {3'b000, 5'd0} || level_flat !== '0)
            $display("FAIL mid_reset: got busy=%b done=%b err=%b bu=%0d lv=%h want all 0",
                     busy, done, error, bits_used, level_flat);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_coeff();
        test_overflow();
        test_t1_only();
        test_prefix14();
        test_prefix15();
        test_suffix_adapt();
        test_prefix16();
        test_stall_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
